// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand read with writeback bypass,
// immediate substitution, stall/flush control and a sticky HALT state.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        valid_in,
    input  logic        stall,
    input  logic        flush,
    output logic [3:0]  SrcReg1,
    output logic [3:0]  SrcReg2,
    input  logic [15:0] SrcData1,
    input  logic [15:0] SrcData2,
    input  logic        wb_en,
    input  logic [3:0]  wb_reg,
    input  logic [15:0] wb_data,
    output logic        ex_valid,
    output logic [3:0]  ex_opcode,
    output logic [3:0]  ex_rd,
    output logic [15:0] ex_op1,
    output logic [15:0] ex_op2,
    output logic        ex_regwrite,
    output logic        halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state;
    logic [3:0]  opcode;
    logic        is_halt;
    logic        is_imm;
    logic [15:0] rd_op1;
    logic [15:0] rd_op2;
    logic [15:0] op2;
    logic        bubble;
    logic        capture;

    assign opcode  = instr[15:12];
    assign SrcReg1 = instr[7:4];
    assign SrcReg2 = instr[3:0];
    assign is_halt = (opcode == 4'hF);
    assign is_imm  = opcode[3] && !is_halt;

    // Same-cycle writeback wins over the stale register-file read
    assign rd_op1 = (wb_en && wb_reg == SrcReg1) ? wb_data : SrcData1;
    assign rd_op2 = (wb_en && wb_reg == SrcReg2) ? wb_data : SrcData2;
    assign op2    = is_imm ? {{12{instr[3]}}, instr[3:0]} : rd_op2;

    assign bubble  = flush || (!stall && (state == HALT || !valid_in));
    assign capture = !flush && !stall && state == RUN && valid_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            halted      <= 1'b0;
            ex_valid    <= 1'b0;
            ex_opcode   <= 4'h0;
            ex_rd       <= 4'h0;
            ex_op1      <= 16'h0;
            ex_op2      <= 16'h0;
            ex_regwrite <= 1'b0;
        end else if (bubble) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= 4'h0;
            ex_rd       <= 4'h0;
            ex_op1      <= 16'h0;
            ex_op2      <= 16'h0;
            ex_regwrite <= 1'b0;
        end else if (capture) begin
            ex_valid    <= 1'b1;
            ex_opcode   <= opcode;
            ex_rd       <= instr[11:8];
            ex_op1      <= rd_op1;
            ex_op2      <= op2;
            ex_regwrite <= !is_halt;
            if (is_halt) begin
                state  <= HALT;
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        valid_in = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  SrcReg1, SrcReg2;
    logic [15:0] SrcData1 = '0;
    logic [15:0] SrcData2 = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_reg = '0;
    logic [15:0] wb_data = '0;
    logic        ex_valid, ex_regwrite, halted;
    logic [3:0]  ex_opcode, ex_rd;
    logic [15:0] ex_op1, ex_op2;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .instr(instr), .valid_in(valid_in),
        .stall(stall), .flush(flush),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .SrcData1(SrcData1), .SrcData2(SrcData2),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_regwrite(ex_regwrite),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic        m_valid, m_rw, m_halt;
    logic [3:0]  m_opc, m_rd;
    logic [15:0] m_op1, m_op2;

    function automatic logic [15:0] read_port(input logic [3:0] a,
                                              input logic [15:0] d);
        if (wb_en && wb_reg == a) return wb_data;
        return d;
    endfunction

    function automatic logic [15:0] operand2();
        int v;
        int op;
        op = int'(instr[15:12]);
        if (op >= 8 && op != 15) begin
            v = int'(instr[3:0]);
            if (v > 7) v = v - 16;
            return v[15:0];
        end
        return read_port(instr[3:0], SrcData2);
    endfunction

    logic m_take, m_keep;
    assign m_keep = stall && !flush;
    assign m_take = !flush && !stall && !m_halt && valid_in;

    always @(posedge clk or posedge rst) begin
        if (rst || !(m_keep || m_take)) begin
            m_valid <= 1'b0; m_opc <= '0; m_rd <= '0;
            m_op1 <= '0; m_op2 <= '0; m_rw <= 1'b0;
            if (rst) m_halt <= 1'b0;
        end else if (m_take) begin
            m_valid <= 1'b1;
            m_opc   <= instr[15:12];
            m_rd    <= instr[11:8];
            m_op1   <= read_port(instr[7:4], SrcData1);
            m_op2   <= operand2();
            m_rw    <= instr[15:12] != 4'hF;
            if (instr[15:12] == 4'hF) m_halt <= 1'b1;
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        check("ex_valid", 16'(ex_valid), 16'(m_valid));
        check("ex_opcode", 16'(ex_opcode), 16'(m_opc));
        check("ex_rd", 16'(ex_rd), 16'(m_rd));
        check("ex_op1", ex_op1, m_op1);
        check("ex_op2", ex_op2, m_op2);
        check("ex_regwrite", 16'(ex_regwrite), 16'(m_rw));
        check("halted", 16'(halted), 16'(m_halt));
        check("SrcReg1", 16'(SrcReg1), 16'(instr[7:4]));
        check("SrcReg2", 16'(SrcReg2), 16'(instr[3:0]));
    end

    task automatic drive(input logic [15:0] i, input logic v,
                         input logic st, input logic fl,
                         input logic [15:0] d1, input logic [15:0] d2,
                         input logic we, input logic [3:0] wr,
                         input logic [15:0] wd);
        @(negedge clk);
        #2;
        instr = i; valid_in = v; stall = st; flush = fl;
        SrcData1 = d1; SrcData2 = d2;
        wb_en = we; wb_reg = wr; wb_data = wd;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".ex_valid"}, 16'(ex_valid), 16'h0);
        check({tag, ".ex_opcode"}, 16'(ex_opcode), 16'h0);
        check({tag, ".ex_rd"}, 16'(ex_rd), 16'h0);
        check({tag, ".ex_op1"}, ex_op1, 16'h0);
        check({tag, ".ex_op2"}, ex_op2, 16'h0);
        check({tag, ".ex_regwrite"}, 16'(ex_regwrite), 16'h0);
        check({tag, ".halted"}, 16'(halted), 16'h0);
    endtask

    initial begin
        #1 check_zero("reset");
        @(negedge clk);
        #2 rst = 1'b0;

        // Basic capture
        drive(16'h3412, 1, 0, 0, 16'h0005, 16'h0007, 0, 4'h0, 16'h0);
        #1;
        check("basic.SrcReg1", 16'(SrcReg1), 16'h1);
        check("basic.SrcReg2", 16'(SrcReg2), 16'h2);
        after_edge();
        check("basic.ex_valid", 16'(ex_valid), 16'h1);
        check("basic.ex_opcode", 16'(ex_opcode), 16'h3);
        check("basic.ex_rd", 16'(ex_rd), 16'h4);
        check("basic.ex_op1", ex_op1, 16'h0005);
        check("basic.ex_op2", ex_op2, 16'h0007);
        check("basic.ex_regwrite", 16'(ex_regwrite), 16'h1);

        // Bypass on port 1 only
        drive(16'h2512, 1, 0, 0, 16'h0001, 16'h1234, 1, 4'h1, 16'hBEEF);
        after_edge();
        check("bypass.ex_op1", ex_op1, 16'hBEEF);
        check("bypass.ex_op2", ex_op2, 16'h1234);

        // Immediate
        drive(16'h930E, 1, 0, 0, 16'h1111, 16'h2222, 1, 4'hE, 16'h5555);
        after_edge();
        check("imm.ex_op2", ex_op2, 16'hFFFE);
        check("imm.ex_rd", 16'(ex_rd), 16'h3);
        check("imm.ex_regwrite", 16'(ex_regwrite), 16'h1);

        // Stall holds, stall+flush bubbles
        drive(16'h1123, 1, 0, 0, 16'h00AA, 16'h00BB, 0, 4'h0, 16'h0);
        after_edge();
        for (int k = 0; k < 2; k++) begin
            drive(16'h4567, 1, 1, 0, 16'h0F0F, 16'hF0F0, 0, 4'h0, 16'h0);
            after_edge();
            check("stall.ex_opcode", 16'(ex_opcode), 16'h1);
            check("stall.ex_op1", ex_op1, 16'h00AA);
            check("stall.ex_op2", ex_op2, 16'h00BB);
            check("stall.ex_valid", 16'(ex_valid), 16'h1);
        end
        drive(16'h4567, 1, 1, 1, 16'h0F0F, 16'hF0F0, 0, 4'h0, 16'h0);
        after_edge();
        check("flush.ex_valid", 16'(ex_valid), 16'h0);
        check("flush.ex_regwrite", 16'(ex_regwrite), 16'h0);
        check("flush.ex_op1", ex_op1, 16'h0);

        // Flushed halt does not halt, captured halt does
        drive(16'hF000, 1, 0, 1, 16'h0, 16'h0, 0, 4'h0, 16'h0);
        after_edge();
        check("fl_halt.halted", 16'(halted), 16'h0);
        drive(16'hF000, 1, 0, 0, 16'h0, 16'h0, 0, 4'h0, 16'h0);
        after_edge();
        check("halt.ex_valid", 16'(ex_valid), 16'h1);
        check("halt.ex_regwrite", 16'(ex_regwrite), 16'h0);
        check("halt.halted", 16'(halted), 16'h1);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        rst = 1'b0;
        drive(16'h1123, 1, 0, 0, 16'h0033, 16'h0044, 0, 4'h0, 16'h0);
        after_edge();
        check("resume.ex_valid", 16'(ex_valid), 16'h1);
        check("resume.ex_op1", ex_op1, 16'h0033);

        // In HALT valid instructions become bubbles
        drive(16'hF000, 1, 0, 0, 16'h0, 16'h0, 0, 4'h0, 16'h0);
        after_edge();
        drive(16'h1123, 1, 0, 0, 16'h0033, 16'h0044, 0, 4'h0, 16'h0);
        after_edge();
        check("halted.ex_valid", 16'(ex_valid), 16'h0);
        check("halted.halted", 16'(halted), 16'h1);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            logic [15:0] ri;
            logic [3:0]  wr;
            ri = 16'($urandom);
            wr = ($urandom_range(1, 0) == 1) ? ri[7:4] : 4'($urandom);
            if ($urandom_range(1, 0) == 1) wr = ri[3:0];
            drive(ri, $urandom_range(3, 0) != 0,
                  $urandom_range(4, 0) == 0, $urandom_range(6, 0) == 0,
                  16'($urandom), 16'($urandom),
                  $urandom_range(1, 0) == 1, wr, 16'($urandom));
            if ($urandom_range(9, 0) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, reset; one clock, reset asynchronous and active-high.
REQ-003 SHALL have instr, input, 16, fetched instruction; opcode [15:12], rd [11:8], rs [7:4], rt [3:0].
REQ-004 SHALL have valid_in, input, 1, instr is a real instruction this cycle.
REQ-005 SHALL have stall, input, 1, hold all ex_* registers this cycle.
REQ-006 SHALL have flush, input, 1, insert bubble this cycle.
REQ-007 SHALL have SrcReg1, output, 4, register-file read address 1, combinational.
REQ-008 SHALL have SrcReg2, output, 4, register-file read address 2, combinational.
REQ-009 SHALL have SrcData1, input, 16, register-file read data 1, same-cycle.
REQ-010 SHALL have SrcData2, input, 16, register-file read data 2, same-cycle.
REQ-011 SHALL have wb_en, input, 1, writeback writing register file this cycle.
REQ-012 SHALL have wb_reg, input, 4, writeback destination register.
REQ-013 SHALL have wb_data, input, 16, writeback data.
REQ-014 SHALL have ex_valid, ex_opcode[3:0], ex_rd[3:0], ex_op1[15:0], ex_op2[15:0], ex_regwrite outputs, all registered.
REQ-015 SHALL have halted, output, 1, registered, high while in HALT state.

Function
REQ-016 SHALL drive SrcReg1 = instr[7:4]; SrcReg2 = instr[3:0], regardless of valid_in.
REQ-017 SHALL form op1 = (wb_en && wb_reg==SrcReg1) ? wb_data : SrcData1; op2 likewise with SrcReg2/SrcData2 (write-to-read bypass).
REQ-018 SHALL, for opcode[3]==1 and opcode!=4'hF, replace op2 with instr[3:0] sign-extended to 16 bits; bypass irrelevant.
REQ-019 SHALL set capture regwrite = 1 for all opcodes except 4'hF.
REQ-020 SHALL implement two states RUN and HALT; RUN after reset.
REQ-021 SHALL, in RUN, no stall, no flush, valid_in=1: on edge load ex_valid=1, ex_opcode, ex_rd=instr[11:8], ex_op1, ex_op2, ex_regwrite; latency 1 cycle.
REQ-022 SHALL, in RUN, no stall, no flush, valid_in=0: load ex_valid=0, ex_regwrite=0; other ex_* fields don't-care but SHALL load 0.
REQ-023 SHALL, when stall=1 and flush=0: keep all ex_* and state unchanged.
REQ-024 SHALL, when flush=1 (any stall): load bubble (ex_valid=0, ex_regwrite=0, fields 0); state unchanged; flush has priority over stall.
REQ-025 SHALL transition RUN->HALT on an edge that captures valid opcode 4'hF (REQ-021 path only); that capture gives ex_valid=1, ex_regwrite=0.
REQ-026 SHALL NOT enter HALT if the 4'hF instruction is stalled or flushed that cycle.
REQ-027 SHALL, in HALT, ignore valid_in and load bubbles each unstalled edge; exit only via rst.
REQ-028 SHALL drive halted=1 from the edge entering HALT onward.

Reset
REQ-029 SHALL, on rst assertion (asynchronous, mid-operation included), immediately force ex_valid=0, ex_opcode=0, ex_rd=0, ex_op1=0, ex_op2=0, ex_regwrite=0, halted=0, state RUN.
REQ-030 SHALL resume normal capture on the first rising edge after rst deasserts.

Verification
REQ-031 SHALL test: rst=1 then 0; instr=16'h3412, valid_in=1, SrcData1=16'h0005, SrcData2=16'h0007, wb_en=0 -> SrcReg1=1, SrcReg2=2; next edge ex_valid=1, ex_opcode=3, ex_rd=4, ex_op1=0005, ex_op2=0007, ex_regwrite=1.
REQ-032 SHALL test bypass: instr=16'h2512, wb_en=1, wb_reg=1, wb_data=16'hBEEF, SrcData1=16'h0001 -> ex_op1=BEEF, ex_op2=SrcData2.
REQ-033 SHALL test immediate: instr=16'h930E (opcode 9), valid_in=1 -> ex_op2=16'hFFFE, ex_rd=3.
REQ-034 SHALL test stall/flush: capture 16'h1123, then stall=1 with new instr for 2 cycles -> ex_* unchanged; stall=1 and flush=1 -> ex_valid=0, ex_regwrite=0.
REQ-035 SHALL test halt: valid 16'hF000 captured -> ex_valid=1, ex_regwrite=0, halted=1; subsequent valid 16'h1123 -> ex_valid=0; 16'hF000 with flush=1 -> halted stays 0.
REQ-036 SHALL test async reset mid-operation: rst pulsed between edges while ex_valid=1, halted=1 -> all outputs 0 before next edge; normal capture resumes after deassert.
